// File: rtl/present_sbox_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : present_sbox_layer_ctrl
// Purpose  : Streams the 16 nibbles of a 3-share masked PRESENT state through
//            a shared LAT-deep S-box pipeline and writes results back in place.
// Revision : 1.0 - initial release
// ============================================================================
module present_sbox_layer_ctrl #(
    parameter int LAT   = 3,
    parameter int RND_W = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_s1,
    input  logic [63:0]      in_s2,
    input  logic [63:0]      in_s3,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [RND_W-1:0] rnd,
    output logic             sbox_en,
    output logic [RND_W-1:0] sbox_r,
    output logic [3:0]       sbox_in1,
    output logic [3:0]       sbox_in2,
    output logic [3:0]       sbox_in3,
    input  logic [3:0]       sbox_out1,
    input  logic [3:0]       sbox_out2,
    input  logic [3:0]       sbox_out3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_s1,
    output logic [63:0]      out_s2,
    output logic [63:0]      out_s3,
    output logic             busy
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;
    localparam logic [1:0] c_out   = 2'd3;

    logic [1:0]     r_state;
    logic [63:0]    r_work1;
    logic [63:0]    r_work2;
    logic [63:0]    r_work3;
    logic [3:0]     r_issue;
    logic [3:0]     r_wb;
    logic [LAT-1:0] r_tag_v;
    logic [3:0]     r_tag_idx [LAT];

    logic           w_en;
    logic           w_issue;
    logic           w_wb;
    logic [3:0]     w_tail_idx;
    logic [5:0]     w_issue_pos;
    logic [5:0]     w_wb_pos;

    // The pipeline only moves when a fresh random word is available.
    assign w_en        = ((r_state == c_run) || (r_state == c_drain)) && rnd_valid;
    assign w_issue     = w_en && (r_state == c_run);
    assign w_wb        = w_en && r_tag_v[LAT-1];
    assign w_tail_idx  = r_tag_idx[LAT-1];
    assign w_issue_pos = {r_issue, 2'b00};
    assign w_wb_pos    = {w_tail_idx, 2'b00};

    assign sbox_en   = w_en;
    assign rnd_ready = w_en;
    assign sbox_r    = rnd;

    assign sbox_in1 = (r_state == c_run) ? r_work1[w_issue_pos +: 4] : 4'h0;
    assign sbox_in2 = (r_state == c_run) ? r_work2[w_issue_pos +: 4] : 4'h0;
    assign sbox_in3 = (r_state == c_run) ? r_work3[w_issue_pos +: 4] : 4'h0;

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state == c_out);
    assign busy      = (r_state != c_idle);

    // Shares are only exposed while the result is being offered.
    assign out_s1 = (r_state == c_out) ? r_work1 : 64'h0;
    assign out_s2 = (r_state == c_out) ? r_work2 : 64'h0;
    assign out_s3 = (r_state == c_out) ? r_work3 : 64'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_issue <= 4'h0;
            r_wb    <= 4'h0;
            r_work1 <= 64'h0;
            r_work2 <= 64'h0;
            r_work3 <= 64'h0;
            r_tag_v <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_tag_idx[k] <= 4'h0;
            end
        end else begin
            if (w_en) begin
                for (int k = LAT-1; k > 0; k--) begin
                    r_tag_v[k]   <= r_tag_v[k-1];
                    r_tag_idx[k] <= r_tag_idx[k-1];
                end
                r_tag_v[0]   <= w_issue;
                r_tag_idx[0] <= r_issue;
            end

            // Writeback targets a nibble already issued, never the one being read.
            if (w_wb) begin
                r_work1[w_wb_pos +: 4] <= sbox_out1;
                r_work2[w_wb_pos +: 4] <= sbox_out2;
                r_work3[w_wb_pos +: 4] <= sbox_out3;
                r_wb                   <= r_wb + 4'd1;
            end

            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_work1 <= in_s1;
                        r_work2 <= in_s2;
                        r_work3 <= in_s3;
                        r_issue <= 4'h0;
                        r_wb    <= 4'h0;
                        r_state <= c_run;
                    end
                end
                c_run: begin
                    if (w_issue) begin
                        r_issue <= r_issue + 4'd1;
                        if (r_issue == 4'd15) begin
                            r_state <= c_drain;
                        end
                    end
                end
                c_drain: begin
                    if (w_wb && (r_wb == 4'd15)) begin
                        r_state <= c_out;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_state <= c_idle;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_present_sbox_layer_ctrl.sv
`default_nettype none
// Testbench for present_sbox_layer_ctrl: table of runs checked against a
// nibble-wise PRESENT S-box layer model and an enable-counting latency model.
module tb_present_sbox_layer_ctrl;

    localparam int LAT   = 3;
    localparam int RND_W = 35;
    localparam int NEN   = 16 + LAT;
    localparam int NVEC  = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [63:0]      in_s1 = '0;
    logic [63:0]      in_s2 = '0;
    logic [63:0]      in_s3 = '0;
    logic             rnd_valid = 1'b0;
    logic             rnd_ready;
    logic [RND_W-1:0] rnd = '0;
    logic             sbox_en;
    logic [RND_W-1:0] sbox_r;
    logic [3:0]       sbox_in1, sbox_in2, sbox_in3;
    logic [3:0]       sbox_out1, sbox_out2, sbox_out3;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      out_s1, out_s2, out_s3;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    present_sbox_layer_ctrl #(.LAT(LAT), .RND_W(RND_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
        .sbox_en(sbox_en), .sbox_r(sbox_r),
        .sbox_in1(sbox_in1), .sbox_in2(sbox_in2), .sbox_in3(sbox_in3),
        .sbox_out1(sbox_out1), .sbox_out2(sbox_out2), .sbox_out3(sbox_out3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3),
        .busy(busy)
    );

    function automatic logic [3:0] present_s(input logic [3:0] x);
        case (x)
            4'h0: present_s = 4'hC;  4'h1: present_s = 4'h5;
            4'h2: present_s = 4'h6;  4'h3: present_s = 4'hB;
            4'h4: present_s = 4'h9;  4'h5: present_s = 4'h0;
            4'h6: present_s = 4'hA;  4'h7: present_s = 4'hD;
            4'h8: present_s = 4'h3;  4'h9: present_s = 4'hE;
            4'hA: present_s = 4'hF;  4'hB: present_s = 4'h8;
            4'hC: present_s = 4'h4;  4'hD: present_s = 4'h7;
            4'hE: present_s = 4'h1;  default: present_s = 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] ref_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = present_s(x[4*i +: 4]);
        return y;
    endfunction

    // Masked S-box pipeline stand-in: output shares XOR to S(input XOR), freshly remasked.
    function automatic logic [11:0] sbox_shares(input logic [3:0] a, input logic [3:0] b,
                                                input logic [3:0] c);
        logic [3:0] m1, m2;
        m1 = 4'($urandom_range(0, 15));
        m2 = 4'($urandom_range(0, 15));
        return {present_s(a ^ b ^ c) ^ m1 ^ m2, m1, m2};
    endfunction

    logic [11:0] pipe [LAT];
    always @(posedge clk) begin
        if (sbox_en) begin
            for (int k = LAT-1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= sbox_shares(sbox_in1, sbox_in2, sbox_in3);
        end
    end
    assign {sbox_out1, sbox_out2, sbox_out3} = pipe[LAT-1];

    typedef struct {
        logic [63:0] state;
        int          stall_at;
        int          stall_len;
        int          bp_len;
        bit          rand_rnd;
        bit          poke;
        logic [63:0] exp_xor;
        int          exp_lat;   // -1: take latency from the enable-count model
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [63:0] st);
        logic [63:0] m1, m2;
        for (int w = 0; w < 50 && !in_ready; w++) @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        m1 = {$urandom, $urandom};
        m2 = {$urandom, $urandom};
        in_s1 = m1; in_s2 = m2; in_s3 = st ^ m1 ^ m2;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, nen, stall_left, ov_cyc, exp_ov, exp_lat;
        bit stalled, en_bad, seq_bad, in_bad, hold_bad, exp_en;
        logic [63:0] rr, h1, h2, h3;
        cyc = 1; nen = 0; stall_left = 0; ov_cyc = 0; exp_ov = 0;
        stalled = 0; en_bad = 0; seq_bad = 0; in_bad = 0; hold_bad = 0;
        out_ready = 1'b0;
        start_run(v.state);
        while (cyc < 300) begin
            rr = {$urandom, $urandom};
            rnd = rr[RND_W-1:0];
            if (v.stall_at >= 0 && !stalled && nen == v.stall_at) begin
                stalled = 1; stall_left = v.stall_len;
            end
            if (stall_left > 0) begin
                rnd_valid = 1'b0; stall_left--;
            end else begin
                rnd_valid = v.rand_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (v.poke && cyc == 5) begin
                in_valid = 1'b1;
                in_s1 = {$urandom, $urandom}; in_s2 = {$urandom, $urandom};
                in_s3 = {$urandom, $urandom};
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (v.poke && cyc == 5 && in_ready) in_bad = 1;
            exp_en = (nen < NEN) && rnd_valid;
            if (sbox_en !== exp_en || rnd_ready !== exp_en) en_bad = 1;
            if (sbox_en && sbox_r !== rnd) en_bad = 1;
            if (out_valid) begin
                ov_cyc = cyc;
                break;
            end
            if (nen >= 16 && {sbox_in1, sbox_in2, sbox_in3} !== 12'h0) seq_bad = 1;
            if (sbox_en) begin
                if (nen < 16 && (sbox_in1 ^ sbox_in2 ^ sbox_in3) !== v.state[4*nen +: 4])
                    seq_bad = 1;
                nen++;
            end
            if (nen == NEN && exp_ov == 0) exp_ov = cyc + 1;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        exp_lat = (v.exp_lat >= 0) ? v.exp_lat : exp_ov;
        check("latency", 64'(ov_cyc), 64'(exp_lat));
        check("rnd_words", 64'(nen), 64'(NEN));
        check("enable_rule", 64'(en_bad), 64'd0);
        check("issue_order", 64'(seq_bad), 64'd0);
        if (v.poke) check("ignored_start", 64'(in_bad), 64'd0);
        h1 = out_s1; h2 = out_s2; h3 = out_s3;
        check("result_xor", h1 ^ h2 ^ h3, v.exp_xor);
        for (int i = 0; i < v.bp_len; i++) begin
            @(negedge clk);
            rnd_valid = 1'b1;
            #1;
            if (!out_valid || in_ready || sbox_en || out_s1 !== h1 || out_s2 !== h2 || out_s3 !== h3)
                hold_bad = 1;
        end
        if (v.bp_len > 0) check("backpressure_hold", 64'(hold_bad), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_handshake", {61'd0, busy, in_ready, out_valid}, 64'b010);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{64'h0123456789ABCDEF, -1, 0, 0,  0, 0, 64'hC56B90AD3EF84712, 20};
        vecs[1] = '{64'h0123456789ABCDEF,  7, 5, 0,  0, 0, 64'hC56B90AD3EF84712, 25};
        vecs[2] = '{64'h0123456789ABCDEF, -1, 0, 10, 0, 0, 64'hC56B90AD3EF84712, 20};
        vecs[3] = '{64'h0123456789ABCDEF, -1, 0, 0,  0, 1, 64'hC56B90AD3EF84712, 20};
        vecs[4] = '{64'h0,                -1, 0, 0,  0, 0, 64'hCCCCCCCCCCCCCCCC, 20};
        vecs[5] = '{64'h0,                -1, 0, 0,  0, 0, 64'hCCCCCCCCCCCCCCCC, 20};
        for (int i = 6; i < NVEC; i++) begin
            vecs[i].state     = {$urandom, $urandom};
            vecs[i].stall_at  = int'($urandom_range(0, 15));
            vecs[i].stall_len = int'($urandom_range(0, 4));
            vecs[i].bp_len    = int'($urandom_range(0, 5));
            vecs[i].rand_rnd  = 1'b1;
            vecs[i].poke      = 1'b0;
            vecs[i].exp_xor   = ref_layer(vecs[i].state);
            vecs[i].exp_lat   = -1;
        end

        // Reset state
        rnd_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_flags", {59'd0, busy, in_ready, out_valid, sbox_en, rnd_ready}, 64'b01000);
        check("reset_sbox_in", {52'd0, sbox_in1, sbox_in2, sbox_in3}, 64'd0);
        check("reset_out_s", out_s1 | out_s2 | out_s3, 64'd0);
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in the middle of a run
        start_run(64'h0123456789ABCDEF);
        rnd_valid = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("midrun_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrun_reset_flags", {60'd0, busy, in_ready, out_valid, sbox_en}, 64'b0100);
        check("midrun_reset_out_s", out_s1 | out_s2 | out_s3, 64'd0);
        @(negedge clk);

        for (int i = 6; i < NVEC; i++) run_vec(vecs[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
